// File: rtl/wb_writer.sv
// Write-back stage: selects ALU, PC-link or load data and drives the register file write port.
// Loads wait on a memory ready handshake with timeout and stall upstream meanwhile.
`timescale 1ns/1ps
module wb_writer #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned OP_W        = 3,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              clk_50MHz,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_reg_op,
    input  logic [ADDR_W-1:0] in_wb_addr,
    input  logic [1:0]        in_wb_sel,
    input  logic [DATA_W-1:0] in_alu_data,
    input  logic [DATA_W-1:0] in_pc_link,
    input  logic              flush,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_req,
    output logic [OP_W-1:0]   reg_op,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic              mem_err,
    output logic [15:0]       retire_cnt
);

    localparam logic [OP_W-1:0] OP_NOP   = '0;
    localparam logic [OP_W-1:0] OP_REG   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_MAX   = OP_W'(5);
    localparam int unsigned     CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWaitMem, StCommit} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OP_W-1:0]     op_lat_q, op_lat_d;
    logic [ADDR_W-1:0]   addr_lat_q, addr_lat_d;
    logic [OP_W-1:0]     reg_op_q, reg_op_d;
    logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic                stall_q, stall_d;
    logic                fwd_valid_q, fwd_valid_d;
    logic [ADDR_W-1:0]   fwd_addr_q, fwd_addr_d;
    logic [DATA_W-1:0]   fwd_data_q, fwd_data_d;
    logic                mem_err_q, mem_err_d;
    logic [15:0]         retire_q, retire_d;

    logic [OP_W-1:0]     eff_op;
    logic                accept;
    logic                timeout;
    logic [DATA_W-1:0]   alu_pc_data;
    logic [DATA_W-1:0]   load_data;

    // Illegal codes 6 and 7 collapse to NOP
    assign eff_op      = (in_reg_op <= OP_MAX) ? in_reg_op : OP_NOP;
    assign accept      = (state_q == StIdle) && in_valid && !flush && (eff_op != OP_NOP);
    assign timeout     = (cnt_q == CNT_LAST);
    assign alu_pc_data = (in_wb_sel == 2'd2) ? in_pc_link : in_alu_data;
    assign load_data   = mem_ready ? mem_rdata : '1;

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_lat_q    <= OP_NOP;
            addr_lat_q  <= '0;
            reg_op_q    <= OP_NOP;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            stall_q     <= 1'b0;
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
            mem_err_q   <= 1'b0;
            retire_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_lat_q    <= op_lat_d;
            addr_lat_q  <= addr_lat_d;
            reg_op_q    <= reg_op_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            stall_q     <= stall_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_addr_q  <= fwd_addr_d;
            fwd_data_q  <= fwd_data_d;
            mem_err_q   <= mem_err_d;
            retire_q    <= retire_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept && in_wb_sel == 2'd1) state_d = StWaitMem;
            end
            StWaitMem: begin
                // flush has priority over a coincident mem_ready
                if (flush)                     state_d = StIdle;
                else if (mem_ready || timeout) state_d = StCommit;
            end
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        op_lat_d    = op_lat_q;
        addr_lat_d  = addr_lat_q;
        reg_op_d    = OP_NOP;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        stall_d     = 1'b0;
        fwd_valid_d = 1'b0;
        fwd_addr_d  = fwd_addr_q;
        fwd_data_d  = fwd_data_q;
        mem_err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    fwd_valid_d = (eff_op == OP_REG);
                    fwd_addr_d  = in_wb_addr;
                    if (in_wb_sel == 2'd1) begin
                        op_lat_d   = eff_op;
                        addr_lat_d = in_wb_addr;
                        cnt_d      = '0;
                        stall_d    = 1'b1;
                    end else begin
                        reg_op_d   = eff_op;
                        wb_addr_d  = in_wb_addr;
                        wb_data_d  = alu_pc_data;
                        fwd_data_d = alu_pc_data;
                    end
                end
            end
            StWaitMem: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!flush) begin
                    fwd_valid_d = (op_lat_q == OP_REG);
                    if (mem_ready || timeout) begin
                        reg_op_d   = op_lat_q;
                        wb_addr_d  = addr_lat_q;
                        wb_data_d  = load_data;
                        fwd_addr_d = addr_lat_q;
                        fwd_data_d = load_data;
                        mem_err_d  = !mem_ready;
                    end else begin
                        stall_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign retire_d   = retire_q + 16'(reg_op_d != OP_NOP);

    assign in_ready   = (state_q == StIdle);
    assign stall_req  = stall_q;
    assign reg_op     = reg_op_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;
    assign fwd_valid  = fwd_valid_q;
    assign fwd_addr   = fwd_addr_q;
    assign fwd_data   = fwd_data_q;
    assign mem_err    = mem_err_q;
    assign retire_cnt = retire_q;

endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer; expected writes go through a scoreboard queue checked
// whenever the DUT presents a non-NOP reg_op.
`timescale 1ns/1ps
module tb_wb_writer;

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic        clk_50MHz = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_reg_op;
    logic [2:0]  in_wb_addr;
    logic [1:0]  in_wb_sel;
    logic [15:0] in_alu_data;
    logic [15:0] in_pc_link;
    logic        flush;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        stall_req;
    logic [2:0]  reg_op;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        fwd_valid;
    logic [2:0]  fwd_addr;
    logic [15:0] fwd_data;
    logic        mem_err;
    logic [15:0] retire_cnt;

    int checks = 0;
    int errors = 0;
    int exp_retire = 0;
    wr_t exp_q[$];

    wb_writer #(
        .DATA_W(16), .ADDR_W(3), .OP_W(3), .MEM_TIMEOUT(15)
    ) dut (
        .clk_50MHz  (clk_50MHz),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_reg_op  (in_reg_op),
        .in_wb_addr (in_wb_addr),
        .in_wb_sel  (in_wb_sel),
        .in_alu_data(in_alu_data),
        .in_pc_link (in_pc_link),
        .flush      (flush),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .stall_req  (stall_req),
        .reg_op     (reg_op),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .fwd_valid  (fwd_valid),
        .fwd_addr   (fwd_addr),
        .fwd_data   (fwd_data),
        .mem_err    (mem_err),
        .retire_cnt (retire_cnt)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50MHz);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [2:0] addr, input logic [1:0] sel,
                         input logic [15:0] alu, input logic [15:0] pc);
        in_valid    = 1'b1;
        in_reg_op   = op;
        in_wb_addr  = addr;
        in_wb_sel   = sel;
        in_alu_data = alu;
        in_pc_link  = pc;
    endtask

    task automatic expect_wr(input logic [2:0] op, input logic [2:0] addr, input logic [15:0] d);
        exp_q.push_back(wr_t'({op, addr, d}));
        exp_retire++;
    endtask

    // Scoreboard: every presented write must match the oldest expected one
    always @(negedge clk_50MHz) begin
        if (!rst && reg_op !== 3'd0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(exp_q.size()), 32'd1);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("sb_write", 32'({reg_op, wb_addr, wb_data}), 32'(w));
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_reg_op = '0; in_wb_addr = '0; in_wb_sel = '0;
        in_alu_data = '0; in_pc_link = '0; flush = 1'b0; mem_rdata = '0; mem_ready = 1'b0;
        #5;
        chk("rst_reg_op", 32'(reg_op), 0);
        chk("rst_wb_addr", 32'(wb_addr), 0);
        chk("rst_wb_data", 32'(wb_data), 0);
        chk("rst_stall", 32'(stall_req), 0);
        chk("rst_fwd", 32'({fwd_valid, fwd_addr, fwd_data}), 0);
        chk("rst_mem_err", 32'(mem_err), 0);
        chk("rst_retire", 32'(retire_cnt), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        step();
        rst = 1'b0;
        step();

        // ALU / PC-link back-to-back writes
        drive(3'd1, 3'd3, 2'd0, 16'h1234, 16'h0000); expect_wr(3'd1, 3'd3, 16'h1234);
        step();
        chk("alu1_reg_op", 32'(reg_op), 1);
        chk("alu1_fwd", 32'({fwd_valid, fwd_addr, fwd_data}), 32'({1'b1, 3'd3, 16'h1234}));
        chk("alu1_stall", 32'(stall_req), 0);
        drive(3'd3, 3'd0, 2'd0, 16'h00FF, 16'h0000); expect_wr(3'd3, 3'd0, 16'h00FF);
        step();
        chk("alu2_reg_op", 32'(reg_op), 3);
        chk("alu2_fwd_valid", 32'(fwd_valid), 0);
        chk("alu2_stall", 32'(stall_req), 0);
        drive(3'd5, 3'd1, 2'd2, 16'h9999, 16'h0042); expect_wr(3'd5, 3'd1, 16'h0042);
        step();
        drive(3'd2, 3'd2, 2'd3, 16'h5555, 16'h0043); expect_wr(3'd2, 3'd2, 16'h5555);
        step();
        in_valid = 1'b0;
        step();
        chk("alu_pulse_end", 32'(reg_op), 0);
        chk("alu_hold", 32'({wb_addr, wb_data}), 32'({3'd2, 16'h5555}));
        chk("alu_retire", 32'(retire_cnt), 32'(exp_retire));

        // Flush in IDLE suppresses the accept
        drive(3'd1, 3'd7, 2'd0, 16'hCAFE, 16'h0000); flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("idle_flush", 32'(reg_op), 0);

        // Load with 4-cycle memory delay; ready in the accept cycle is ignored
        drive(3'd1, 3'd5, 2'd1, 16'hAAAA, 16'h0000); expect_wr(3'd1, 3'd5, 16'hBEEF);
        mem_ready = 1'b1; mem_rdata = 16'h1111;
        step();
        in_valid = 1'b0; mem_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk("load_stall", 32'(stall_req), 1);
            chk("load_wait", 32'({in_ready, reg_op, fwd_valid, fwd_addr}), 32'({1'b0, 3'd0, 1'b1, 3'd5}));
            if (i == 4) begin
                mem_ready = 1'b1; mem_rdata = 16'hBEEF;
            end
            step();
        end
        mem_ready = 1'b0;
        chk("load_commit", 32'({stall_req, in_ready, reg_op}), 32'({1'b0, 1'b0, 3'd1}));
        chk("load_fwd", 32'({fwd_valid, fwd_addr, fwd_data}), 32'({1'b1, 3'd5, 16'hBEEF}));
        step();
        chk("load_done", 32'({in_ready, reg_op, fwd_valid}), 32'({1'b1, 3'd0, 1'b0}));

        // Load timeout
        drive(3'd5, 3'd2, 2'd1, 16'h0000, 16'h0000); expect_wr(3'd5, 3'd2, 16'hFFFF);
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            chk("to_wait", 32'({stall_req, mem_err, reg_op, fwd_valid}), 32'({1'b1, 1'b0, 3'd0, 1'b0}));
            step();
        end
        chk("to_commit", 32'({stall_req, mem_err, reg_op, wb_data}), 32'({1'b0, 1'b1, 3'd5, 16'hFFFF}));
        step();
        chk("to_err_pulse", 32'({mem_err, reg_op}), 0);

        // Flush beats mem_ready in WAIT_MEM
        drive(3'd1, 3'd6, 2'd1, 16'h0000, 16'h0000);
        step();
        in_valid = 1'b0;
        chk("fl_wait", 32'(stall_req), 1);
        flush = 1'b1; mem_ready = 1'b1; mem_rdata = 16'hDEAD;
        step();
        flush = 1'b0; mem_ready = 1'b0;
        chk("fl_idle", 32'({stall_req, reg_op, in_ready, fwd_valid, mem_err}), 32'({1'b0, 3'd0, 1'b1, 1'b0, 1'b0}));
        step();
        chk("fl_retire", 32'(retire_cnt), 32'(exp_retire));

        // NOP and illegal op codes
        drive(3'd0, 3'd1, 2'd0, 16'h1111, 16'h0000); step();
        chk("nop0", 32'(reg_op), 0);
        drive(3'd6, 3'd1, 2'd0, 16'h2222, 16'h0000); step();
        chk("nop6", 32'(reg_op), 0);
        drive(3'd7, 3'd1, 2'd1, 16'h3333, 16'h0000); step();
        chk("nop7", 32'({reg_op, stall_req, in_ready}), 32'({3'd0, 1'b0, 1'b1}));
        in_valid = 1'b0;
        step();
        chk("nop_retire", 32'(retire_cnt), 32'(exp_retire));

        // Drive retire_cnt up to FFFF, then wrap on the next write
        begin
            int n;
            n = 65535 - exp_retire;
            for (int i = 0; i < n; i++) begin
                drive(3'd2, 3'd0, 2'd0, 16'(i), 16'h0000); expect_wr(3'd2, 3'd0, 16'(i));
                step();
            end
        end
        in_valid = 1'b0;
        step();
        chk("retire_max", 32'(retire_cnt), 32'h0000FFFF);
        drive(3'd4, 3'd0, 2'd0, 16'h7777, 16'h0000); expect_wr(3'd4, 3'd0, 16'h7777);
        step();
        in_valid = 1'b0;
        step();
        chk("retire_wrap", 32'(retire_cnt), 0);
        exp_retire = 0;

        // Asynchronous reset in the middle of a load
        drive(3'd1, 3'd4, 2'd1, 16'h0000, 16'h0000);
        step();
        in_valid = 1'b0;
        step();
        chk("rl_wait", 32'({stall_req, fwd_valid}), 32'({1'b1, 1'b1}));
        #5 rst = 1'b1;
        #1;
        chk("rl_outputs", 32'({stall_req, fwd_valid, fwd_addr, reg_op, mem_err, in_ready}), 32'(1));
        chk("rl_data", 32'({wb_addr, wb_data}), 0);
        chk("rl_fwd_data", 32'(fwd_data), 0);
        chk("rl_retire", 32'(retire_cnt), 0);
        #4 rst = 1'b0;
        mem_ready = 1'b1; mem_rdata = 16'h4444;
        step(); step(); step();
        mem_ready = 1'b0;
        chk("rl_no_write", 32'({reg_op, retire_cnt}), 0);
        step();
        chk("sb_drain", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
